// File: rtl/axis_flit_injector.sv
// AXI-Stream to NoC flit injector: serializes each beat into flits and
// meters them against a credit counter mirroring the router input buffer.
module axis_flit_injector #(
    parameter int TDATA_WIDTH          = 32,
    parameter int DEST_WIDTH           = 4,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_BUFFER_DEPTH    = 8
) (
    input  logic                                        clk_noc,
    input  logic                                        rst_noc_sync,
    input  logic                                        axis_tvalid,
    output logic                                        axis_tready,
    input  logic [TDATA_WIDTH-1:0]                      axis_tdata,
    input  logic                                        axis_tlast,
    input  logic [DEST_WIDTH-1:0]                       axis_tdest,
    output logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_out,
    output logic [DEST_WIDTH-1:0]                       dest_out,
    output logic                                        is_tail_out,
    output logic                                        send_out,
    input  logic                                        credit_in,
    output logic                                        credit_overflow
);

    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int IW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(SERIALIZATION_FACTOR - 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(FLIT_BUFFER_DEPTH);

    logic                   busy_q, busy_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TDATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                   hold_last_q, hold_last_d;
    logic [DEST_WIDTH-1:0]  hold_dest_q, hold_dest_d;
    logic [CW-1:0]          credits_q, credits_d;
    logic                   send_q, send_d;
    logic [FLIT_WIDTH-1:0]  data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic                   tail_q, tail_d;
    logic                   ovf_q, ovf_d;

    logic fire;
    logic last_fire;
    logic accept;

    assign fire        = busy_q & (credits_q != '0);
    assign last_fire   = fire & (idx_q == IDX_LAST);
    assign axis_tready = ~rst_noc_sync & (~busy_q | last_fire);
    assign accept      = axis_tvalid & axis_tready;

    always_comb begin
        busy_d      = busy_q;
        idx_d       = idx_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_dest_d = hold_dest_q;
        credits_d   = credits_q;
        send_d      = fire;
        data_d      = data_q;
        dest_d      = dest_q;
        tail_d      = tail_q;
        ovf_d       = ovf_q;

        if (fire) begin
            data_d = hold_data_q[int'(idx_q) * FLIT_WIDTH +: FLIT_WIDTH];
            dest_d = hold_dest_q;
            tail_d = hold_last_q & (idx_q == IDX_LAST);
            idx_d  = idx_q + IW'(1);
        end

        if (last_fire) begin
            idx_d  = '0;
            busy_d = 1'b0;
        end

        // A new beat may load in the same cycle the last flit leaves.
        if (accept) begin
            busy_d      = 1'b1;
            hold_data_d = axis_tdata;
            hold_last_d = axis_tlast;
            hold_dest_d = axis_tdest;
        end

        unique case ({fire, credit_in})
            2'b10: credits_d = credits_q - CW'(1);
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk_noc or posedge rst_noc_sync) begin
        if (rst_noc_sync) begin
            busy_q      <= 1'b0;
            idx_q       <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_dest_q <= '0;
            credits_q   <= CRED_MAX;
            send_q      <= 1'b0;
            data_q      <= '0;
            dest_q      <= '0;
            tail_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_dest_q <= hold_dest_d;
            credits_q   <= credits_d;
            send_q      <= send_d;
            data_q      <= data_d;
            dest_q      <= dest_d;
            tail_q      <= tail_d;
            ovf_q       <= ovf_d;
        end
    end

    assign send_out        = send_q;
    assign data_out        = data_q;
    assign dest_out        = dest_q;
    assign is_tail_out     = tail_q;
    assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_axis_flit_injector.sv
// Bench for axis_flit_injector: directed scenarios plus random traffic
// checked against a flit-queue / credit-count reference model.
module tb_axis_flit_injector;

    localparam int TW    = 32;
    localparam int DW    = 4;
    localparam int SF    = 2;
    localparam int DEPTH = 8;
    localparam int FW    = TW / SF;

    typedef struct packed {
        logic [FW-1:0] d;
        logic [DW-1:0] dst;
        logic          t;
    } flit_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tvalid;
    logic          tready;
    logic [TW-1:0] tdata;
    logic          tlast;
    logic [DW-1:0] tdest;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail;
    logic          send;
    logic          credit_in;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    flit_t         q[$];
    int            cred;
    bit            m_ovf;
    bit            e_send;
    logic [FW-1:0] e_data;
    logic [DW-1:0] e_dest;
    logic          e_tail;
    int            nsent;
    bit            last_acc;

    always #5 clk = ~clk;

    axis_flit_injector #(
        .TDATA_WIDTH(TW),
        .DEST_WIDTH(DW),
        .SERIALIZATION_FACTOR(SF),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc(clk),
        .rst_noc_sync(rst),
        .axis_tvalid(tvalid),
        .axis_tready(tready),
        .axis_tdata(tdata),
        .axis_tlast(tlast),
        .axis_tdest(tdest),
        .data_out(data_out),
        .dest_out(dest_out),
        .is_tail_out(is_tail),
        .send_out(send),
        .credit_in(credit_in),
        .credit_overflow(ovf)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_send"}, send, e_send);
        chk({tag, "_data"}, data_out, e_data);
        chk({tag, "_dest"}, dest_out, e_dest);
        chk({tag, "_tail"}, is_tail, e_tail);
        chk({tag, "_ovf"}, ovf, m_ovf);
    endtask

    task automatic model_reset();
        q.delete();
        cred   = DEPTH;
        m_ovf  = 0;
        e_send = 0;
        e_data = '0;
        e_dest = '0;
        e_tail = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        tvalid    = 1'b0;
        credit_in = 1'b0;
        rst       = 1'b1;
        #1;
        model_reset();
        chk({tag, "_rst_outs"}, {send, data_out, dest_out, is_tail, ovf}, '0);
        chk({tag, "_rst_rdy"}, tready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({tag, "_rel_rdy"}, tready, 1'b1);
    endtask

    // One clock cycle: drive, predict, clock, compare.
    task automatic step(input logic v, input logic [TW-1:0] d, input logic l,
                        input logic [DW-1:0] dst, input logic cr);
        bit    fire_m;
        bit    rdy_m;
        flit_t f;
        @(negedge clk);
        tvalid    = v;
        tdata     = d;
        tlast     = l;
        tdest     = dst;
        credit_in = cr;
        #1;
        fire_m = (q.size() > 0) && (cred > 0);
        rdy_m  = (q.size() == 0) || (q.size() == 1 && fire_m);
        chk("tready", tready, rdy_m);
        last_acc = v && rdy_m;
        @(posedge clk);
        e_send = fire_m;
        if (fire_m) begin
            f      = q.pop_front();
            e_data = f.d;
            e_dest = f.dst;
            e_tail = f.t;
            nsent++;
        end
        if (last_acc) begin
            for (int k = 0; k < SF; k++) begin
                f.d   = d[k*FW +: FW];
                f.dst = dst;
                f.t   = l && (k == SF - 1);
                q.push_back(f);
            end
        end
        if (cr && !fire_m && cred == DEPTH) m_ovf = 1;
        else cred = cred - int'(fire_m) + int'(cr);
        #1;
        chk_outs("out");
    endtask

    logic [TW-1:0] beats[5];
    logic [TW-1:0] rd;
    logic [DW-1:0] rdst;
    logic          rl;
    bit            rv;
    int            b;
    int            n0;

    initial begin
        rst       = 1'b1;
        tvalid    = 1'b0;
        tdata     = '0;
        tlast     = 1'b0;
        tdest     = '0;
        credit_in = 1'b0;
        nsent     = 0;
        model_reset();
        #1;
        chk("por_outs", {send, data_out, dest_out, is_tail, ovf}, '0);
        chk("por_rdy", tready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single two-flit beat, LS slice first.
        step(1'b1, 32'hAABBCCDD, 1'b1, 4'h5, 1'b0);
        chk("b1_nosend_yet", send, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("b1_f0", {send, data_out, dest_out, is_tail}, {1'b1, 16'hCCDD, 4'h5, 1'b0});
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("b1_f1", {send, data_out, dest_out, is_tail}, {1'b1, 16'hAABB, 4'h5, 1'b1});
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("b1_idle", {send, data_out}, {1'b0, 16'hAABB});

        // Five beats with no credit return: stall after eight flits.
        do_reset("s31");
        foreach (beats[i]) beats[i] = $urandom;
        b     = 0;
        nsent = 0;
        for (int i = 0; i < 14; i++) begin
            step(b < 5, (b < 5) ? beats[b] : '0, b == 4, 4'h3, 1'b0);
            if (last_acc) b++;
        end
        chk("s31_sent8", nsent, 8);
        chk("s31_stall", {send, tready}, 2'b00);
        n0 = nsent;
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("s31_c1", send, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("s31_c2", {send, data_out}, {1'b1, beats[4][15:0]});
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("s31_one", nsent - n0, 1);

        // Fire and credit return together at credits=1.
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b1, 32'h12345678, 1'b1, 4'h9, 1'b1);
        chk("s34_last", {send, data_out, is_tail}, {1'b1, beats[4][31:16], 1'b1});
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("s34_nobubble", {send, data_out}, {1'b1, 16'h5678});

        // Credits returned every cycle: six contiguous flits.
        do_reset("s32");
        b = 0;
        step(1'b1, 32'h11112222, 1'b0, 4'h1, 1'b0);
        b = 1;
        for (int i = 0; i < 6; i++) begin
            step(b < 3, 32'h33334444 + b, b == 2, 4'h1, 1'b1);
            if (last_acc) b++;
            chk("s32_send", send, 1'b1);
            chk("s32_tail", is_tail, i == 5);
        end
        chk("s32_noovf", ovf, 1'b0);

        // Credit return on a full counter latches overflow.
        do_reset("s33");
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("s33_ovf", ovf, 1'b1);
        step(1'b1, 32'hCAFEF00D, 1'b1, 4'h2, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("s33_held", ovf, 1'b1);

        // Reset between the two flits of a beat.
        do_reset("s35a");
        step(1'b1, 32'hDEADBEEF, 1'b1, 4'h7, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("s35_first", {send, data_out}, {1'b1, 16'hBEEF});
        nsent = 0;
        do_reset("s35b");
        repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0);
        chk("s35_dropped", nsent, 0);
        for (int i = 0; i < 12; i++) step(1'b1, 32'h0 + i, 1'b0, 4'h0, 1'b0);
        chk("s35_cred8", nsent, 8);

        // Random traffic.
        do_reset("rnd");
        rv   = 1'b0;
        rd   = '0;
        rl   = 1'b0;
        rdst = '0;
        for (int i = 0; i < 600; i++) begin
            if (!rv) begin
                rv   = ($urandom % 4) != 0;
                rd   = $urandom;
                rl   = $urandom % 2;
                rdst = DW'($urandom);
            end
            if ($urandom % 150 == 0) begin
                do_reset("rnd");
                rv = 1'b0;
            end else begin
                step(rv, rd, rl, rdst, ($urandom % 2) == 1);
                if (last_acc) rv = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
